panel_switch_ctrl: RTL and testbench
====================================

# panel_switch_ctrl

Front-panel switch controller sitting between the keyboard cursor block and the CPU front-panel command interface. It turns cursor index/action changes into switch state and CPU commands:
- 18 latching toggle switches;
- 5 momentary command switches;
- 2 latching aux switches.

It sequences multi-step commands (EXAMINE/DEPOSIT NEXT, loader deposits) over a single valid/ready command port shared between the panel and an OSD image loader.

## Interface
- SW_TOGGLE_COUNT, 18, indices 0..17 are latching toggles; bits 15:0 form address/data word
- AUX1_INDEX, 23, latching aux switch 1
- AUX2_INDEX, 24, latching aux switch 2
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset; one clock
- cursor_index  in  5  selected switch, 0..24
- cursor_action  in  2  0 centre/off, 1 up/on, 2 down, 3 navigate (no effect)
- ld_valid  in  1  loader deposit request
- ld_addr  in  16  loader target address
- ld_data  in  8  loader byte
- ld_ready  out  1  loader request accepted this cycle
- sw_state  out  18  toggle switch positions
- aux_state  out  2  AUX1 (bit0), AUX2 (bit1) positions
- cmd_valid  out  1  command presented to CPU
- cmd_code  out  4  command code
- cmd_addr  out  16  command address
- cmd_data  out  8  command data
- cmd_ready  in  1  CPU accepts command
- cmd_dropped  out  1  one-cycle pulse: panel event discarded

## Operation
- Inputs registered once. Event = registered cursor_action differs from its previous registered value and the new value is 0, 1 or 2. Action 3 never generates an event.
- Toggle index (0..17) events:
  - action 1 sets sw_state[index]; actions 0 and 2 clear it.
  - No command is generated.
- Aux index (23, 24) events:
  - action 1 sets the bit, action 2 also sets it, action 0 clears it.
  - No command is generated.
- Momentary index events (action 1 = up, 2 = down; action 0 = release, no command):
  - 18: up STOP (1), down RUN (2).
  - 19: up STEP (3), down ignored.
  - 20: up EXAMINE (4), down EXAMINE_NEXT (5).
  - 21: up DEPOSIT (6), down DEPOSIT_NEXT (7, two-step).
  - 22: up RESET (8), down CLR (9).
- Panel command payload:
  - cmd_addr = sw_state[15:0], cmd_data = sw_state[7:0], sampled at the event.
- One-entry panel pending register:
  - A momentary event with pending empty loads it.
  - A momentary event with pending full is discarded and pulses cmd_dropped.
- FSM states IDLE, CMD1, CMD2:
  - IDLE: pending full → load panel command, go CMD1, pending cleared. Else ld_valid → ld_ready=1 for one cycle, latch addr/data, go CMD1. Panel has strict priority.
  - CMD1: cmd_valid=1. On cmd_ready: if two-step go CMD2, else IDLE.
  - CMD2: cmd_valid=1. On cmd_ready go IDLE.
- Two-step commands:
  - DEPOSIT_NEXT: CMD1 = EXAMINE_NEXT (5); CMD2 = DEPOSIT (6) with same data.
  - Loader request: CMD1 = EXAMINE (4) at ld_addr; CMD2 = DEPOSIT (6) with ld_data, cmd_addr = ld_addr.
- Codes 0, 10..15 are never emitted.

## Timing
- Reset values: all outputs 0; FSM IDLE; pending empty; previous-action register = 3, so no spurious event after reset.
- Input change → sw_state/aux_state update: 2 cycles (input register + event register).
- Input change → cmd_valid: earliest 3 cycles when IDLE.
- cmd_valid and payload held stable until cmd_ready; transfer completes in the cycle both are high.
- Back-to-back: CMD1→CMD2 allows cmd_valid to stay high across the transfer with a new payload next cycle.
- IDLE lasts ≥1 cycle between commands.
- ld_ready is asserted only in IDLE with pending empty; it is never combinationally dependent on cmd_ready.
- A panel event in the same cycle as a loader grant is captured in pending and issued next.
- A toggle change while a command is in flight does not alter the latched payload.
- reset_n low mid-command: cmd_valid drops immediately; the command is lost.

## Structure
- Shared package panel_pkg:
  - command code constants CMD_STOP..CMD_CLR;
  - switch index constants for 18..24;
  - FSM state typedef.
- Sub-module panel_event_det: input register, previous-action register, event strobe plus decoded index class.
- Main module holds the switch registers, pending register and FSM.

## Test plan
- Toggles: index 5 action 3→1 → sw_state[5]=1 at +2 cycles. Then 1→0 → cleared. Action 3 alone → no change.
- Single command: sw_state=0x1234, index 20 action 3→1 → cmd_valid with code 4, addr 0x1234, data 0x34. Hold cmd_ready=0 for 5 cycles → payload stable.
- DEPOSIT_NEXT: sw_state[7:0]=0xAB, index 21 action 2 → code 5 transfer, then code 6 with data 0xAB, then IDLE.
- Loader: ld_valid with 0x0100/0x3E → EXAMINE 0x0100, then DEPOSIT 0x0100/0x3E. ld_ready pulses once.
- Arbitration: STOP event and ld_valid in the same cycle → STOP issued first. A third panel event while pending is full → cmd_dropped pulse.
- Reset: reset_n low during CMD2 → all outputs 0 asynchronously. After release, no command until a new action change.

Source files
------------

// File: rtl/panel_pkg.sv
// rtl/panel_pkg.sv - shared constants, types and command decode for the front-panel switch controller
package panel_pkg;

  localparam int SW_TOGGLE_COUNT = 18;

  localparam logic [4:0] IDX_STOP_RUN = 5'd18;
  localparam logic [4:0] IDX_STEP     = 5'd19;
  localparam logic [4:0] IDX_EXAMINE  = 5'd20;
  localparam logic [4:0] IDX_DEPOSIT  = 5'd21;
  localparam logic [4:0] IDX_RESET    = 5'd22;
  localparam logic [4:0] AUX1_INDEX   = 5'd23;
  localparam logic [4:0] AUX2_INDEX   = 5'd24;

  localparam logic [1:0] ACT_OFF  = 2'd0;
  localparam logic [1:0] ACT_UP   = 2'd1;
  localparam logic [1:0] ACT_DOWN = 2'd2;
  localparam logic [1:0] ACT_NAV  = 2'd3;

  localparam logic [3:0] CMD_NONE         = 4'd0;
  localparam logic [3:0] CMD_STOP         = 4'd1;
  localparam logic [3:0] CMD_RUN          = 4'd2;
  localparam logic [3:0] CMD_STEP         = 4'd3;
  localparam logic [3:0] CMD_EXAMINE      = 4'd4;
  localparam logic [3:0] CMD_EXAMINE_NEXT = 4'd5;
  localparam logic [3:0] CMD_DEPOSIT      = 4'd6;
  localparam logic [3:0] CMD_DEPOSIT_NEXT = 4'd7;
  localparam logic [3:0] CMD_RESET        = 4'd8;
  localparam logic [3:0] CMD_CLR          = 4'd9;

  typedef enum logic [1:0] {ST_IDLE, ST_CMD1, ST_CMD2} state_t;
  typedef enum logic [1:0] {CLS_TOGGLE, CLS_MOMENT, CLS_AUX, CLS_NONE} idx_class_t;

  // CMD_NONE means the momentary event carries no command (release, STEP down).
  function automatic logic [3:0] moment_code(input logic [4:0] idx, input logic [1:0] act);
    logic [3:0] code;
    code = CMD_NONE;
    case (idx)
      IDX_STOP_RUN: code = (act == ACT_UP) ? CMD_STOP    : (act == ACT_DOWN) ? CMD_RUN          : CMD_NONE;
      IDX_STEP:     code = (act == ACT_UP) ? CMD_STEP    : CMD_NONE;
      IDX_EXAMINE:  code = (act == ACT_UP) ? CMD_EXAMINE : (act == ACT_DOWN) ? CMD_EXAMINE_NEXT : CMD_NONE;
      IDX_DEPOSIT:  code = (act == ACT_UP) ? CMD_DEPOSIT : (act == ACT_DOWN) ? CMD_DEPOSIT_NEXT : CMD_NONE;
      IDX_RESET:    code = (act == ACT_UP) ? CMD_RESET   : (act == ACT_DOWN) ? CMD_CLR          : CMD_NONE;
      default:      code = CMD_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/panel_event_det.sv
// rtl/panel_event_det.sv - registers cursor inputs and flags action changes with the index class
module panel_event_det
  import panel_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] i_index,
  input  logic [1:0] i_action,
  output logic       o_event,
  output logic [4:0] o_index,
  output logic [1:0] o_action,
  output logic [1:0] o_class
);

  logic [4:0] r_index;
  logic [1:0] r_action;
  logic [1:0] r_prev_action;

  // Both action registers start at navigate so a held cursor cannot fake an event after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index       <= '0;
      r_action      <= ACT_NAV;
      r_prev_action <= ACT_NAV;
    end else begin
      r_index       <= i_index;
      r_action      <= i_action;
      r_prev_action <= r_action;
    end
  end

  assign o_event  = (r_action != r_prev_action) && (r_action != ACT_NAV);
  assign o_index  = r_index;
  assign o_action = r_action;

  always_comb begin
    o_class = CLS_NONE;
    if (r_index < IDX_STOP_RUN)     o_class = CLS_TOGGLE;
    else if (r_index <= IDX_RESET)  o_class = CLS_MOMENT;
    else if (r_index <= AUX2_INDEX) o_class = CLS_AUX;
  end

endmodule

// File: rtl/panel_switch_ctrl.sv
// rtl/panel_switch_ctrl.sv - front-panel switch state, pending panel command and shared command port FSM
module panel_switch_ctrl
  import panel_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [4:0]                 cursor_index,
  input  logic [1:0]                 cursor_action,
  input  logic                       ld_valid,
  input  logic [15:0]                ld_addr,
  input  logic [7:0]                 ld_data,
  output logic                       ld_ready,
  output logic [SW_TOGGLE_COUNT-1:0] sw_state,
  output logic [1:0]                 aux_state,
  output logic                       cmd_valid,
  output logic [3:0]                 cmd_code,
  output logic [15:0]                cmd_addr,
  output logic [7:0]                 cmd_data,
  input  logic                       cmd_ready,
  output logic                       cmd_dropped
);

  logic       w_event;
  logic [4:0] w_idx;
  logic [1:0] w_act;
  logic [1:0] w_class;
  logic [3:0] w_mom_code;
  logic       w_cmd_event;
  logic       w_take_pend;

  logic [SW_TOGGLE_COUNT-1:0] r_sw;
  logic [1:0]                 r_aux;

  logic        r_pend_valid;
  logic [3:0]  r_pend_code;
  logic [15:0] r_pend_addr;
  logic [7:0]  r_pend_data;
  logic        r_dropped;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_code;
  logic [15:0] r_addr;
  logic [7:0]  r_data;
  logic        r_two_step;

  panel_event_det u_event_det (
    .clk      (clk),
    .rst_n    (reset_n),
    .i_index  (cursor_index),
    .i_action (cursor_action),
    .o_event  (w_event),
    .o_index  (w_idx),
    .o_action (w_act),
    .o_class  (w_class)
  );

  assign w_mom_code  = moment_code(w_idx, w_act);
  assign w_cmd_event = w_event && (w_class == CLS_MOMENT) && (w_mom_code != CMD_NONE);
  assign w_take_pend = (r_state == ST_IDLE) && r_pend_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sw  <= '0;
      r_aux <= '0;
    end else if (w_event) begin
      if (w_class == CLS_TOGGLE) begin
        r_sw[w_idx] <= (w_act == ACT_UP);
      end else if (w_class == CLS_AUX) begin
        if (w_idx == AUX1_INDEX) r_aux[0] <= (w_act != ACT_OFF);
        else                     r_aux[1] <= (w_act != ACT_OFF);
      end
    end
  end

  // Single-entry buffer: a second panel command while one waits is thrown away.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_valid <= 1'b0;
      r_pend_code  <= CMD_NONE;
      r_pend_addr  <= '0;
      r_pend_data  <= '0;
      r_dropped    <= 1'b0;
    end else begin
      r_dropped <= w_cmd_event && r_pend_valid;
      if (w_cmd_event && !r_pend_valid) begin
        r_pend_valid <= 1'b1;
        r_pend_code  <= w_mom_code;
        r_pend_addr  <= r_sw[15:0];
        r_pend_data  <= r_sw[7:0];
      end else if (w_take_pend) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_code     <= CMD_NONE;
      r_addr     <= '0;
      r_data     <= '0;
      r_two_step <= 1'b0;
    end else if (w_take_pend) begin
      r_two_step <= (r_pend_code == CMD_DEPOSIT_NEXT);
      r_code     <= (r_pend_code == CMD_DEPOSIT_NEXT) ? CMD_EXAMINE_NEXT : r_pend_code;
      r_addr     <= r_pend_addr;
      r_data     <= r_pend_data;
    end else if (ld_ready) begin
      r_two_step <= 1'b1;
      r_code     <= CMD_EXAMINE;
      r_addr     <= ld_addr;
      r_data     <= ld_data;
    end else if ((r_state == ST_CMD1) && cmd_ready && r_two_step) begin
      r_code <= CMD_DEPOSIT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (r_pend_valid || ld_valid) w_next_state = ST_CMD1;
      ST_CMD1: if (cmd_ready) w_next_state = r_two_step ? ST_CMD2 : ST_IDLE;
      ST_CMD2: if (cmd_ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_valid = 1'b0;
    cmd_code  = CMD_NONE;
    cmd_addr  = '0;
    cmd_data  = '0;
    ld_ready  = 1'b0;
    case (r_state)
      ST_IDLE: ld_ready = ld_valid && !r_pend_valid;
      ST_CMD1, ST_CMD2: begin
        cmd_valid = 1'b1;
        cmd_code  = r_code;
        cmd_addr  = r_addr;
        cmd_data  = r_data;
      end
      default: ;
    endcase
  end

  assign sw_state    = r_sw;
  assign aux_state   = r_aux;
  assign cmd_dropped = r_dropped;

endmodule

// File: tb/tb_panel_switch_ctrl.sv
// tb/tb_panel_switch_ctrl.sv - scoreboard bench for panel_switch_ctrl
module tb_panel_switch_ctrl;

  typedef struct packed {
    logic [3:0]  code;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  cursor_index;
  logic [1:0]  cursor_action;
  logic        ld_valid;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic [17:0] sw_state;
  logic [1:0]  aux_state;
  logic        cmd_valid;
  logic [3:0]  cmd_code;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        cmd_ready;
  logic        cmd_dropped;

  exp_t sb[$];
  exp_t mon_e;
  exp_t held;
  logic hold = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   ld_grants = 0;
  int   drops = 0;

  panel_switch_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cursor_index  (cursor_index),
    .cursor_action (cursor_action),
    .ld_valid      (ld_valid),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data),
    .ld_ready      (ld_ready),
    .sw_state      (sw_state),
    .aux_state     (aux_state),
    .cmd_valid     (cmd_valid),
    .cmd_code      (cmd_code),
    .cmd_addr      (cmd_addr),
    .cmd_data      (cmd_data),
    .cmd_ready     (cmd_ready),
    .cmd_dropped   (cmd_dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, want);
    end
  endtask

  // Monitor: pops the scoreboard on every transfer and checks held payloads stay put.
  always @(negedge clk) begin
    if (!reset_n) begin
      hold = 1'b0;
    end else begin
      if (ld_valid && ld_ready) ld_grants++;
      if (cmd_dropped) drops++;
      if (hold) check("hold_stable", {3'b0, cmd_valid, cmd_code, cmd_addr, cmd_data}, {4'b0001, held});
      if (cmd_valid && cmd_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_xfer", {4'b0, cmd_code, cmd_addr, cmd_data}, 32'hFFFF_FFFF);
        end else begin
          mon_e = sb.pop_front();
          check("xfer", {4'b0, cmd_code, cmd_addr, cmd_data}, {4'b0, mon_e});
        end
      end
      hold = cmd_valid && !cmd_ready;
      held = {cmd_code, cmd_addr, cmd_data};
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step_neg();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Parks the cursor on navigate first so the next action is always a fresh change.
  task automatic fire(input int idx, input int act);
    logic [4:0] i5;
    logic [1:0] a2;
    i5 = idx[4:0];
    a2 = act[1:0];
    cursor_index  = i5;
    cursor_action = 2'd3;
    cyc(2);
    cursor_action = a2;
  endtask

  task automatic set_toggle(input int idx, input logic v);
    fire(idx, v ? 1 : 0);
    cyc(3);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || cmd_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_in_time", (t < 300) ? 32'd1 : 32'd0, 32'd1);
    cyc(1);
  endtask

  task automatic wait_grant();
    int t;
    t = 0;
    @(negedge clk);
    while (!ld_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("grant_in_time", (t < 300) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    int d0;
    int t;
    logic seen;
    logic [15:0] v1234;
    logic [7:0]  vab;

    reset_n       = 1'b0;
    cursor_index  = 5'd0;
    cursor_action = 2'd3;
    ld_valid      = 1'b0;
    ld_addr       = 16'h0;
    ld_data       = 8'h0;
    cmd_ready     = 1'b1;
    cyc(3);
    @(negedge clk);
    check("reset_sw", {12'b0, sw_state, aux_state}, 32'h0);
    check("reset_cmd", {1'b0, cmd_valid, cmd_code, cmd_addr, cmd_data, ld_ready, cmd_dropped}, 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    cyc(3);

    // Toggle latency and hold.
    fire(5, 1);
    step_neg();
    check("tog_lat1", {31'b0, sw_state[5]}, 32'd0);
    step_neg();
    check("tog_lat2", {31'b0, sw_state[5]}, 32'd1);
    cyc(1);
    cursor_action = 2'd3;
    cyc(4);
    check("tog_nav_noop", {31'b0, sw_state[5]}, 32'd1);
    cursor_action = 2'd0;
    cyc(3);
    check("tog_clear", {14'b0, sw_state}, 32'd0);

    // Aux switches: down also sets.
    fire(23, 2); cyc(3);
    check("aux1_down", {30'b0, aux_state}, 32'd1);
    fire(24, 1); cyc(3);
    check("aux2_up", {30'b0, aux_state}, 32'd3);
    fire(23, 0); cyc(3);
    check("aux1_off", {30'b0, aux_state}, 32'd2);
    check("aux_no_cmd", {31'b0, cmd_valid}, 32'd0);

    // Single EXAMINE held off for 5 cycles.
    v1234 = 16'h1234;
    for (int i = 0; i < 16; i++) if (v1234[i]) set_toggle(i, 1'b1);
    check("sw_1234", {14'b0, sw_state}, 32'h1234);
    cmd_ready = 1'b0;
    sb.push_back({4'd4, 16'h1234, 8'h34});
    fire(20, 1);
    step_neg();
    step_neg();
    check("cmd_lat2", {31'b0, cmd_valid}, 32'd0);
    step_neg();
    check("cmd_lat3", {31'b0, cmd_valid}, 32'd1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 cmd_ready = 1'b1;
    wait_drain();

    // DEPOSIT NEXT splits into EXAMINE NEXT then DEPOSIT.
    vab = 8'hAB;
    for (int i = 0; i < 8; i++) set_toggle(i, vab[i]);
    check("sw_12ab", {14'b0, sw_state}, 32'h12AB);
    sb.push_back({4'd5, 16'h12AB, 8'hAB});
    sb.push_back({4'd6, 16'h12AB, 8'hAB});
    fire(21, 2);
    wait_drain();

    // Loader deposit.
    g0 = ld_grants;
    sb.push_back({4'd4, 16'h0100, 8'h3E});
    sb.push_back({4'd6, 16'h0100, 8'h3E});
    ld_addr  = 16'h0100;
    ld_data  = 8'h3E;
    ld_valid = 1'b1;
    wait_grant();
    wait_drain();
    check("ld_ready_once", ld_grants - g0, 32'd1);

    // Panel beats the loader; third panel event is dropped.
    g0 = ld_grants;
    d0 = drops;
    cmd_ready = 1'b0;
    ld_addr   = 16'h0200;
    ld_data   = 8'h5A;
    sb.push_back({4'd1, 16'h12AB, 8'hAB});
    sb.push_back({4'd2, 16'h12AB, 8'hAB});
    sb.push_back({4'd4, 16'h0200, 8'h5A});
    sb.push_back({4'd6, 16'h0200, 8'h5A});
    fire(18, 1);
    cyc(2);
    ld_valid = 1'b1;
    @(negedge clk);
    check("arb_panel_first", {31'b0, ld_ready}, 32'd0);
    fire(18, 2); cyc(3);
    fire(22, 1); cyc(4);
    check("drop_pulse", drops - d0, 32'd1);
    cmd_ready = 1'b1;
    wait_grant();
    wait_drain();
    check("arb_ld_once", ld_grants - g0, 32'd1);

    // Reset during CMD2 loses the command.
    cmd_ready = 1'b0;
    sb.push_back({4'd5, 16'h12AB, 8'hAB});
    fire(21, 2);
    t = 0;
    @(negedge clk);
    while (!cmd_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("rst_cmd_seen", {31'b0, cmd_valid}, 32'd1);
    @(posedge clk);
    #1 cmd_ready = 1'b1;
    @(posedge clk);
    #1 cmd_ready = 1'b0;
    @(negedge clk);
    check("cmd2_present", {27'b0, cmd_valid, cmd_code}, {27'b0, 1'b1, 4'd6});
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("rst_async_cmd", {1'b0, cmd_valid, cmd_code, cmd_addr, cmd_data, ld_ready, cmd_dropped}, 32'h0);
    check("rst_async_sw", {12'b0, sw_state, aux_state}, 32'h0);
    cursor_action = 2'd3;
    cyc(2);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (cmd_valid) seen = 1'b1;
    end
    check("post_reset_quiet", {31'b0, seen}, 32'd0);
    check("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
